led_strip_sequencer: RTL
========================

// Module: led_strip_sequencer
// PURPOSE
//  Frame-level controller for led_driver. On start, walks NUM_LEDS pixels from a synchronous pixel RAM,
//  applies a global brightness scale and hands each 24-bit word to led_driver via a one-cycle load.
//  It waits for the driver's done, then holds a latch gap so the strip latches. Sits between the frame
//  buffer / top-level FSM and the single led_driver instance.
// PARAMETERS
//  NUM_LEDS       16     pixels per frame (>=1)
//  RESET_CYCLES   3840   latch gap after last pixel, clk cycles (80 us @ 48 MHz)
//  TIMEOUT_CYCLES 4096   max wait for drv_done per pixel before abort
// PORTS
//  clk         in   1    system clock
//  rst         in   1    asynchronous, active-low reset
//  start       in   1    frame refresh request, sampled in IDLE only
//  brightness  in   8    global scale, latched on accepted start
//  busy        out  1    high from accepted start until frame_done cycle inclusive
//  frame_done  out  1    one-cycle pulse, frame (or aborted frame) finished
//  err         out  1    one-cycle pulse, drv_done timeout
//  pix_rd      out  1    pixel RAM read strobe
//  pix_addr    out  AW   pixel index, AW = $clog2(NUM_LEDS) (min 1)
//  pix_data    in   24   RAM data, valid the cycle after pix_rd
//  drv_rgb     out  24   word to led_driver, held between loads
//  drv_load    out  1    one-cycle load strobe to led_driver
//  drv_done    in   1    led_driver completion (pulse or level)
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, idx=0, all outputs 0, scale register 0.
//  - FSM: IDLE -> FETCH -> CAPTURE -> LOAD -> WAIT_DONE -> (FETCH | LATCH) -> FINISH -> IDLE.
//  - IDLE: start=1 -> latch brightness, idx=0, busy=1, go FETCH next cycle. start ignored in other states.
//  - FETCH: pix_rd=1, pix_addr=idx (1 cycle).
//  - CAPTURE: drv_rgb <= scale(pix_data) registered; channel c' = (c*(brightness+1))>>8 per byte,
//    16-bit product, truncate to 8 bits; 255 -> identity, 0 -> all zero.
//  - LOAD: drv_load=1 exactly one cycle; drv_rgb stable. pix_rd->drv_load latency = 2 cycles.
//  - WAIT_DONE: advance on rising edge of drv_done (registered previous value), so a held level
//    advances once. If idx==NUM_LEDS-1 -> LATCH else idx++ -> FETCH. drv_done outside WAIT_DONE ignored.
//  - Timeout: TIMEOUT_CYCLES in WAIT_DONE without edge -> err=1 one cycle, go LATCH (frame aborted).
//  - LATCH: count RESET_CYCLES cycles, no strobes. FINISH: frame_done=1, busy=1 this cycle, then IDLE.
//  - start in FINISH ignored; new frame needs start in IDLE (earliest cycle after frame_done).
//  - Counters: idx AW bits, no wrap past NUM_LEDS-1; shared gap/timeout counter, width
//    $clog2(max(RESET_CYCLES,TIMEOUT_CYCLES)+1), cleared on every state entry.
//  - Reset mid-frame: immediate return to reset values; no partial load; next start begins at addr 0.
// STRUCTURE
//  - led_pkg: typedef enum logic [2:0] seq_state_t; RGB_W=24, CH_W=8 constants.
//  - Sub-module led_color_scale: 24-bit rgb + 8-bit brightness -> 24-bit scaled (combinational);
//    sequencer registers its output into drv_rgb.
//  - Sequencer: FSM, idx counter, gap/timeout counter, done edge detect.
// TESTING
//  1. NUM_LEDS=4, RESET_CYCLES=20, RAM={FF0000,00FF00,0000FF,123456}, brightness=255, start; RAM model
//     + driver model (done pulse 30 cycles after load) -> pix_addr 0..3, 4 loads with exact RAM words,
//     frame_done >=20 cycles after last done, busy drops after frame_done.
//  2. Pixel {8'd0,8'd206,8'd255}, brightness=128 -> drv_rgb={8'd0,8'd103,8'd128}; brightness=0 -> 000000.
//  3. start pulsed mid-frame and brightness changed to 0 mid-frame -> no restart, all 4 words at
//     original scale, exactly one frame_done.
//  4. Driver model holds drv_done high until next load -> exactly one advance per load, 4 loads total.
//  5. Driver never asserts done, TIMEOUT_CYCLES=50 -> err pulse 50 cycles after first load, no further
//     loads, frame_done after RESET_CYCLES gap.
//  6. rst=0 during WAIT_DONE of pixel 2 -> all outputs 0 asynchronously; after release, start ->
//     pix_addr restarts at 0, full 4-pixel frame completes.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the LED strip sequencer and its colour scaler.
package led_pkg;

  localparam int RGB_W = 24;
  localparam int CH_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_LOAD,
    S_WAIT_DONE,
    S_LATCH,
    S_FINISH
  } seq_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_color_scale.sv
// Per-channel brightness scaling: c' = (c * (brightness + 1)) >> 8, purely combinational.
module led_color_scale
  import led_pkg::*;
(
  input  logic [RGB_W-1:0] rgb,
  input  logic [CH_W-1:0]  brightness,
  output logic [RGB_W-1:0] scaled
);

  logic [CH_W:0] gain;

  // brightness+1 makes 255 an exact identity and keeps 0 fully dark
  assign gain = {1'b0, brightness} + {{CH_W{1'b0}}, 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < RGB_W / CH_W; gi++) begin : g_ch
      assign scaled[gi*CH_W +: CH_W] =
        CH_W'(({{CH_W{1'b0}}, rgb[gi*CH_W +: CH_W]} * {{(CH_W-1){1'b0}}, gain}) >> CH_W);
    end
  endgenerate

endmodule

// File: rtl/led_strip_sequencer.sv
// Frame controller: streams NUM_LEDS scaled pixels from RAM into led_driver, then holds a latch gap.
module led_strip_sequencer
  import led_pkg::*;
#(
  parameter int  NUM_LEDS       = 16,
  parameter int  RESET_CYCLES   = 3840,
  parameter int  TIMEOUT_CYCLES = 4096,
  localparam int AW             = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CH_W-1:0]  brightness,
  output logic             busy,
  output logic             frame_done,
  output logic             err,
  output logic             pix_rd,
  output logic [AW-1:0]    pix_addr,
  input  logic [RGB_W-1:0] pix_data,
  output logic [RGB_W-1:0] drv_rgb,
  output logic             drv_load,
  input  logic             drv_done
);

  localparam int CW = $clog2(max_int(RESET_CYCLES, TIMEOUT_CYCLES) + 1);

  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_LEDS - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_END  = CW'(TIMEOUT_CYCLES - 1);

  seq_state_t       state_reg, state_next;
  logic [AW-1:0]    idx_reg, idx_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [CH_W-1:0]  scale_reg, scale_next;
  logic [RGB_W-1:0] rgb_reg, rgb_next;
  logic             done_prev_reg;
  logic             done_edge;
  logic [RGB_W-1:0] scaled_rgb;

  led_color_scale u_scale (
    .rgb        (pix_data),
    .brightness (scale_reg),
    .scaled     (scaled_rgb)
  );

  // a held done level advances the walk exactly once
  assign done_edge = drv_done & ~done_prev_reg;
  assign pix_addr  = idx_reg;
  assign drv_rgb   = rgb_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      scale_reg     <= '0;
      rgb_reg       <= '0;
      done_prev_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      cnt_reg       <= cnt_next;
      scale_reg     <= scale_next;
      rgb_reg       <= rgb_next;
      done_prev_reg <= drv_done;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    scale_next = scale_reg;
    rgb_next   = rgb_reg;
    pix_rd     = 1'b0;
    drv_load   = 1'b0;
    frame_done = 1'b0;
    err        = 1'b0;
    busy       = (state_reg != S_IDLE);

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          scale_next = brightness;
          idx_next   = '0;
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        pix_rd     = 1'b1;
        state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        rgb_next   = scaled_rgb;
        state_next = S_LOAD;
      end
      S_LOAD: begin
        drv_load   = 1'b1;
        state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (done_edge) begin
          if (idx_reg == LAST_IDX) begin
            state_next = S_LATCH;
          end else begin
            idx_next   = idx_reg + {{(AW-1){1'b0}}, 1'b1};
            state_next = S_FETCH;
          end
        end else if (cnt_reg == WAIT_END) begin
          // driver stalled: abandon the rest of the frame but still latch the strip
          err        = 1'b1;
          state_next = S_LATCH;
        end
      end
      S_LATCH: begin
        if (cnt_reg == GAP_END) begin
          state_next = S_FINISH;
        end
      end
      S_FINISH: begin
        frame_done = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // one counter serves both the timeout and the latch gap; every state entry restarts it
    if ((state_next != state_reg) ||
        ((state_reg != S_WAIT_DONE) && (state_reg != S_LATCH))) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule
